// File: rtl/pc_gen_pkg.sv
// Shared opcode encodings, default addresses and next-PC source tags for the
// program-counter generator and its return-address stack.
package pc_gen_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BGEZ = 3'd3;
    localparam logic [2:0] BR_BGTZ = 3'd4;
    localparam logic [2:0] BR_BLEZ = 3'd5;
    localparam logic [2:0] BR_BLTZ = 3'd6;

    localparam logic [2:0] JMP_NONE = 3'd0;
    localparam logic [2:0] JMP_J    = 3'd1;
    localparam logic [2:0] JMP_JAL  = 3'd2;
    localparam logic [2:0] JMP_JR   = 3'd3;
    localparam logic [2:0] JMP_JALR = 3'd4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_VEC  = 32'h0000_4180;

    // Next-PC source, listed in decreasing priority.
    typedef enum logic [2:0] {
        SRC_EXC  = 3'd0,
        SRC_EPC  = 3'd1,
        SRC_HOLD = 3'd2,
        SRC_BR   = 3'd3,
        SRC_J    = 3'd4,
        SRC_JR   = 3'd5,
        SRC_SEQ  = 3'd6
    } npc_src_e;

    // Branch condition from the ID-stage compare flags; code 7 is never taken.
    function automatic logic br_taken(input logic [2:0] op, input logic zero,
                                      input logic great, input logic less);
        logic t;
        case (op)
            BR_BEQ:  t = zero;
            BR_BNE:  t = ~zero;
            BR_BGEZ: t = zero | great;
            BR_BGTZ: t = great;
            BR_BLEZ: t = zero | less;
            BR_BLTZ: t = less;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored. The top read is combinational and zero when empty.
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  push_data,
    output logic [ADDR_W-1:0]                  top,
    output logic                               valid,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     count
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH+1);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_ptr_inc;
    logic [PTR_W-1:0]  w_ptr_dec;
    logic              w_empty;
    logic              w_full;

    // Pointer arithmetic modulo RAS_DEPTH, which need not be a power of two.
    always_comb begin
        w_empty = (r_count == {CNT_W{1'b0}});
        w_full  = (r_count == CNT_W'(RAS_DEPTH));
        if (r_ptr == PTR_W'(RAS_DEPTH-1)) begin
            w_ptr_inc = {PTR_W{1'b0}};
        end else begin
            w_ptr_inc = r_ptr + PTR_W'(1);
        end
        if (r_ptr == {PTR_W{1'b0}}) begin
            w_ptr_dec = PTR_W'(RAS_DEPTH-1);
        end else begin
            w_ptr_dec = r_ptr - PTR_W'(1);
        end
    end

    // Stack state: pointer, occupancy and entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= {ADDR_W{1'b0}};
            end
        end else if (push) begin
            r_ptr            <= w_ptr_inc;
            r_mem[w_ptr_inc] <= push_data;
            if (!w_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (pop && !w_empty) begin
            r_ptr   <= w_ptr_dec;
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign valid = ~w_empty;
    assign count = r_count;
    assign top   = w_empty ? {ADDR_W{1'b0}} : r_mem[r_ptr];

endmodule

// File: rtl/pc_gen.sv
// Registered program counter with prioritised redirect (interrupt, ERET,
// stall hold, branch, jump) and an advisory return-address stack.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEFAULT_EXC_VEC),
    parameter int                RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           intreq,
    input  logic                           eret,
    input  logic [ADDR_W-1:0]              epc,
    input  logic [ADDR_W-1:0]              id_pc4,
    input  logic [2:0]                     br_op,
    input  logic                           zero,
    input  logic                           great,
    input  logic                           less,
    input  logic [ADDR_W-1:0]              offset,
    input  logic [2:0]                     jmp_op,
    input  logic                           jr_is_ra,
    input  logic [25:0]                    instr_index,
    input  logic [ADDR_W-1:0]              jr_pc,
    output logic [ADDR_W-1:0]              pc,
    output logic [ADDR_W-1:0]              pc4,
    output logic [ADDR_W-1:0]              npc,
    output logic                           redirect,
    output logic                           pc_misalign,
    output logic [ADDR_W-1:0]              ras_top,
    output logic                           ras_valid,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_pc_misalign;
    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_b_tgt;
    logic [ADDR_W-1:0] w_j_tgt;
    logic [ADDR_W-1:0] w_npc_sel;
    logic [ADDR_W-1:0] w_npc;
    logic              w_taken;
    logic              w_redirect;
    logic              w_ras_en;
    logic              w_push;
    logic              w_pop;
    npc_src_e          w_src;

    assign w_pc4   = r_pc + ADDR_W'(4);
    assign w_b_tgt = id_pc4 + (offset << 2);
    assign w_j_tgt = {id_pc4[ADDR_W-1:28], instr_index, 2'b00};
    assign w_taken = br_taken(br_op, zero, great, less);

    // Priority select of the next-PC source; a stall masks branch/jump requests.
    always_comb begin
        w_src = SRC_SEQ;
        if (intreq) begin
            w_src = SRC_EXC;
        end else if (eret) begin
            w_src = SRC_EPC;
        end else if (stall) begin
            w_src = SRC_HOLD;
        end else if (w_taken) begin
            w_src = SRC_BR;
        end else if ((jmp_op == JMP_J) || (jmp_op == JMP_JAL)) begin
            w_src = SRC_J;
        end else if ((jmp_op == JMP_JR) || (jmp_op == JMP_JALR)) begin
            w_src = SRC_JR;
        end else begin
            w_src = SRC_SEQ;
        end
    end

    // Next-PC mux and redirect flag; reset overrides everything.
    always_comb begin
        w_npc_sel  = w_pc4;
        w_redirect = 1'b0;
        case (w_src)
            SRC_EXC:  begin w_npc_sel = EXC_VEC; w_redirect = 1'b1; end
            SRC_EPC:  begin w_npc_sel = epc;     w_redirect = 1'b1; end
            SRC_HOLD: begin w_npc_sel = r_pc;    w_redirect = 1'b0; end
            SRC_BR:   begin w_npc_sel = w_b_tgt; w_redirect = 1'b1; end
            SRC_J:    begin w_npc_sel = w_j_tgt; w_redirect = 1'b1; end
            SRC_JR:   begin w_npc_sel = jr_pc;   w_redirect = 1'b1; end
            SRC_SEQ:  begin w_npc_sel = w_pc4;   w_redirect = 1'b0; end
            default:  begin w_npc_sel = w_pc4;   w_redirect = 1'b0; end
        endcase
        if (reset) begin
            w_npc      = RESET_PC;
            w_redirect = 1'b0;
        end else begin
            w_npc = w_npc_sel;
        end
    end

    // PC register and alignment flag, updated every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_pc_misalign <= |RESET_PC[1:0];
        end else begin
            r_pc          <= w_npc;
            r_pc_misalign <= |w_npc[1:0];
        end
    end

    // Calls push the address after the delay slot; only jr $31 counts as a return.
    always_comb begin
        w_ras_en = ~reset & ~intreq & ~eret & ~stall;
        w_push   = w_ras_en & ((jmp_op == JMP_JAL) | (jmp_op == JMP_JALR));
        w_pop    = w_ras_en & (jmp_op == JMP_JR) & jr_is_ra;
    end

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (id_pc4 + ADDR_W'(4)),
        .top       (ras_top),
        .valid     (ras_valid),
        .count     (ras_count)
    );

    assign pc          = r_pc;
    assign pc4         = w_pc4;
    assign npc         = w_npc;
    assign redirect    = w_redirect;
    assign pc_misalign = r_pc_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a vector table for the next-PC priority and
// targets, then hand sequences for RAS overflow/underflow and reset.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, stall, intreq, eret, zero, great, less, jr_is_ra;
    logic [31:0] epc, id_pc4, offset, jr_pc;
    logic [2:0]  br_op, jmp_op;
    logic [25:0] instr_index;
    logic [31:0] pc, pc4, npc, ras_top;
    logic        redirect, pc_misalign, ras_valid;
    logic [2:0]  ras_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .intreq(intreq), .eret(eret),
        .epc(epc), .id_pc4(id_pc4), .br_op(br_op), .zero(zero), .great(great),
        .less(less), .offset(offset), .jmp_op(jmp_op), .jr_is_ra(jr_is_ra),
        .instr_index(instr_index), .jr_pc(jr_pc), .pc(pc), .pc4(pc4), .npc(npc),
        .redirect(redirect), .pc_misalign(pc_misalign), .ras_top(ras_top),
        .ras_valid(ras_valid), .ras_count(ras_count)
    );

    typedef struct {
        logic        stall, intreq, eret;
        logic [31:0] epc, id_pc4;
        logic [2:0]  br_op;
        logic        zero, great, less;
        logic [31:0] offset;
        logic [2:0]  jmp_op;
        logic        jr_is_ra;
        logic [25:0] instr_index;
        logic [31:0] jr_pc;
        logic [31:0] e_npc;
        logic        e_redir;
        logic [31:0] e_pc;
        logic        e_mis;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall = 1'b0; intreq = 1'b0; eret = 1'b0; epc = 32'h0; id_pc4 = 32'h0;
        br_op = 3'd0; zero = 1'b0; great = 1'b0; less = 1'b0; offset = 32'h0;
        jmp_op = 3'd0; jr_is_ra = 1'b0; instr_index = 26'h0; jr_pc = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stall intreq eret epc id_pc4 br zero great less offset jmp ra idx jr_pc | npc redir pc mis cnt
        vecs[0]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,3'd0,1'b0,1'b0,1'b0,32'h0,3'd0,1'b0,26'h0,32'h0, 32'h3004,1'b0,32'h3004,1'b0,3'd0};
        vecs[1]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,3'd0,1'b0,1'b0,1'b0,32'h0,3'd0,1'b0,26'h0,32'h0, 32'h3008,1'b0,32'h3008,1'b0,3'd0};
        vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,3'd0,1'b0,1'b0,1'b0,32'h0,3'd0,1'b0,26'h0,32'h0, 32'h300C,1'b0,32'h300C,1'b0,3'd0};
        vecs[3]  = '{1'b0,1'b0,1'b0,32'h0,32'h3010,3'd1,1'b1,1'b0,1'b0,32'hFFFF_FFFE,3'd0,1'b0,26'h0,32'h0, 32'h3008,1'b1,32'h3008,1'b0,3'd0};
        vecs[4]  = '{1'b0,1'b0,1'b0,32'h0,32'h3010,3'd1,1'b0,1'b0,1'b0,32'hFFFF_FFFE,3'd0,1'b0,26'h0,32'h0, 32'h300C,1'b0,32'h300C,1'b0,3'd0};
        vecs[5]  = '{1'b1,1'b0,1'b0,32'h0,32'h3010,3'd2,1'b0,1'b0,1'b0,32'h4,3'd0,1'b0,26'h0,32'h0, 32'h300C,1'b0,32'h300C,1'b0,3'd0};
        vecs[6]  = '{1'b1,1'b0,1'b0,32'h0,32'h3010,3'd2,1'b0,1'b0,1'b0,32'h4,3'd2,1'b0,26'h0,32'h0, 32'h300C,1'b0,32'h300C,1'b0,3'd0};
        vecs[7]  = '{1'b1,1'b1,1'b0,32'h0,32'h3010,3'd2,1'b0,1'b0,1'b0,32'h4,3'd0,1'b0,26'h0,32'h0, 32'h4180,1'b1,32'h4180,1'b0,3'd0};
        vecs[8]  = '{1'b1,1'b0,1'b1,32'h3100,32'h3010,3'd2,1'b0,1'b0,1'b0,32'h4,3'd0,1'b0,26'h0,32'h0, 32'h3100,1'b1,32'h3100,1'b0,3'd0};
        vecs[9]  = '{1'b0,1'b0,1'b0,32'h0,32'h3100,3'd3,1'b0,1'b1,1'b0,32'h4,3'd0,1'b0,26'h0,32'h0, 32'h3110,1'b1,32'h3110,1'b0,3'd0};
        vecs[10] = '{1'b0,1'b0,1'b0,32'h0,32'h3100,3'd4,1'b1,1'b0,1'b0,32'h4,3'd0,1'b0,26'h0,32'h0, 32'h3114,1'b0,32'h3114,1'b0,3'd0};
        vecs[11] = '{1'b0,1'b0,1'b0,32'h0,32'h3200,3'd5,1'b0,1'b0,1'b1,32'h10,3'd0,1'b0,26'h0,32'h0, 32'h3240,1'b1,32'h3240,1'b0,3'd0};
        vecs[12] = '{1'b0,1'b0,1'b0,32'h0,32'h3200,3'd6,1'b1,1'b0,1'b0,32'h10,3'd0,1'b0,26'h0,32'h0, 32'h3244,1'b0,32'h3244,1'b0,3'd0};
        vecs[13] = '{1'b0,1'b0,1'b0,32'h0,32'h3200,3'd7,1'b1,1'b1,1'b1,32'h10,3'd0,1'b0,26'h0,32'h0, 32'h3248,1'b0,32'h3248,1'b0,3'd0};
        vecs[14] = '{1'b0,1'b0,1'b0,32'h0,32'hA000_0004,3'd0,1'b0,1'b0,1'b0,32'h0,3'd1,1'b0,26'h40,32'h0, 32'hA000_0100,1'b1,32'hA000_0100,1'b0,3'd0};
        vecs[15] = '{1'b0,1'b0,1'b0,32'h0,32'hA000_0004,3'd0,1'b0,1'b0,1'b0,32'h0,3'd5,1'b0,26'h40,32'h3000, 32'hA000_0104,1'b0,32'hA000_0104,1'b0,3'd0};
        vecs[16] = '{1'b0,1'b0,1'b0,32'h0,32'h0,3'd0,1'b0,1'b0,1'b0,32'h0,3'd3,1'b0,26'h0,32'h3002, 32'h3002,1'b1,32'h3002,1'b1,3'd0};
        vecs[17] = '{1'b0,1'b0,1'b0,32'h0,32'h3004,3'd0,1'b0,1'b0,1'b0,32'h0,3'd4,1'b0,26'h0,32'h3000, 32'h3000,1'b1,32'h3000,1'b0,3'd1};
        vecs[18] = '{1'b0,1'b0,1'b0,32'h0,32'h0,3'd0,1'b0,1'b0,1'b0,32'h0,3'd3,1'b1,26'h0,32'h3010, 32'h3010,1'b1,32'h3010,1'b0,3'd0};
        vecs[19] = '{1'b0,1'b0,1'b0,32'h0,32'h3020,3'd1,1'b1,1'b0,1'b0,32'h1,3'd1,1'b0,26'h100,32'h0, 32'h3024,1'b1,32'h3024,1'b0,3'd0};

        idle();
        reset = 1'b1;
        repeat (2) tick();
        chk("reset_pc", pc, 32'h3000);
        chk("reset_misalign", {31'd0, pc_misalign}, 32'd0);
        chk("reset_ras_count", {29'd0, ras_count}, 32'd0);
        chk("reset_ras_valid", {31'd0, ras_valid}, 32'd0);
        chk("reset_ras_top", ras_top, 32'd0);
        chk("reset_redirect", {31'd0, redirect}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            stall = vecs[i].stall; intreq = vecs[i].intreq; eret = vecs[i].eret;
            epc = vecs[i].epc; id_pc4 = vecs[i].id_pc4; br_op = vecs[i].br_op;
            zero = vecs[i].zero; great = vecs[i].great; less = vecs[i].less;
            offset = vecs[i].offset; jmp_op = vecs[i].jmp_op; jr_is_ra = vecs[i].jr_is_ra;
            instr_index = vecs[i].instr_index; jr_pc = vecs[i].jr_pc;
            #1;
            chk($sformatf("vec%0d_npc", i), npc, vecs[i].e_npc);
            chk($sformatf("vec%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].e_redir});
            tick();
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_misalign", i), {31'd0, pc_misalign}, {31'd0, vecs[i].e_mis});
            chk($sformatf("vec%0d_ras_count", i), {29'd0, ras_count}, {29'd0, vecs[i].e_cnt});
        end

        // Five calls into a four-entry stack: the oldest return address is lost.
        idle();
        for (int k = 0; k < 5; k++) begin
            jmp_op = 3'd2;
            id_pc4 = 32'h3004 + 32'h100 * k;
            tick();
            chk($sformatf("push%0d_count", k), {29'd0, ras_count}, (k < 4) ? (k + 1) : 4);
        end
        chk("full_top", ras_top, 32'h3408);
        chk("full_valid", {31'd0, ras_valid}, 32'd1);

        begin
            logic [31:0] exp_top [5];
            logic [31:0] exp_cnt [5];
            exp_top = '{32'h3308, 32'h3208, 32'h3108, 32'h0, 32'h0};
            exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
            idle();
            for (int k = 0; k < 5; k++) begin
                jmp_op = 3'd3; jr_is_ra = 1'b1; jr_pc = 32'h3000;
                tick();
                chk($sformatf("pop%0d_top", k), ras_top, exp_top[k]);
                chk($sformatf("pop%0d_count", k), {29'd0, ras_count}, exp_cnt[k]);
                chk($sformatf("pop%0d_valid", k), {31'd0, ras_valid}, (k < 3) ? 32'd1 : 32'd0);
            end
        end

        // A call that coincides with an interrupt must not reach the stack.
        idle();
        jmp_op = 3'd2; id_pc4 = 32'h3504; intreq = 1'b1;
        tick();
        chk("jal_intreq_pc", pc, 32'h4180);
        chk("jal_intreq_count", {29'd0, ras_count}, 32'd0);
        intreq = 1'b0;
        tick();
        chk("jal_push_count", {29'd0, ras_count}, 32'd1);
        chk("jal_push_top", ras_top, 32'h3508);

        // Synchronous reset wins over a concurrent call and interrupt.
        reset = 1'b1; intreq = 1'b1;
        #1;
        chk("reset_active_redirect", {31'd0, redirect}, 32'd0);
        tick();
        chk("reset_jal_pc", pc, 32'h3000);
        chk("reset_jal_count", {29'd0, ras_count}, 32'd0);
        chk("reset_jal_top", ras_top, 32'd0);
        chk("reset_jal_valid", {31'd0, ras_valid}, 32'd0);
        reset = 1'b0;
        idle();
        tick();
        chk("post_reset_pc", pc, 32'h3004);
        chk("post_reset_pc4", pc4, 32'h3008);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Registered program-counter generator for the 5-stage MIPS pipeline. It replaces the purely combinational next-PC select with a PC register plus stall handling.
- Adds a decided redirect priority with interrupts first, and a configurable exception vector and reset PC.
- Adds a parametrised circular return-address stack (RAS). The RAS tracks calls and returns; its top is exported for a future fetch-stage predictor.
- Sits between IF (drives the IM address) and ID (receives branch, jump and compare results).

Parameters:
- ADDR_W, 32, PC width; must be >= 29.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, interrupt/exception handler entry.
- RAS_DEPTH, 4, number of RAS entries; must be >= 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard stall; PC holds and the ID request is ignored
- intreq  in  1  interrupt/exception request
- eret  in  1  ERET is in ID
- epc  in  ADDR_W  return address for ERET
- id_pc4  in  ADDR_W  PC+4 of the instruction in ID
- br_op  in  3  0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 blez, 6 bltz; 7 is treated as none
- zero  in  1  GPR[rs]==GPR[rt] (or rs==0 for the single-operand branches)
- great  in  1  rs>0 signed (or rs>rt)
- less  in  1  rs<0 signed
- offset  in  ADDR_W  sign-extended 16-bit branch offset
- jmp_op  in  3  0 none, 1 j, 2 jal, 3 jr, 4 jalr; 5-7 are treated as none
- jr_is_ra  in  1  jr source register is $31
- instr_index  in  26  J-type index field
- jr_pc  in  ADDR_W  forwarded GPR[rs]
- pc  out  ADDR_W  registered fetch PC
- pc4  out  ADDR_W  pc+4
- npc  out  ADDR_W  combinational next PC
- redirect  out  1  npc differs from the sequential path (taken branch/jump/eret/intreq)
- pc_misalign  out  1  pc[1:0]!=0, registered with pc
- ras_top  out  ADDR_W  top RAS entry; 0 when empty
- ras_valid  out  1  RAS count > 0
- ras_count  out  $clog2(RAS_DEPTH+1)  number of valid entries

Behaviour:
- Reset (synchronous), which dominates all other inputs:
  - pc <= RESET_PC, pc_misalign <= RESET_PC[1:0]!=0.
  - RAS pointer, count and all entries <= 0.
  - Consequently ras_valid=0, ras_top=0, redirect=0.
- Targets:
  - b_tgt = id_pc4 + (offset<<2), modulo 2^ADDR_W.
  - j_tgt = {id_pc4[ADDR_W-1:28], instr_index, 2'b00}.
- Branch taken (taken):
  - beq: zero.
  - bne: !zero.
  - bgez: zero|great.
  - bgtz: great.
  - blez: zero|less.
  - bltz: less.
- npc priority, first match wins:
  1. intreq -> EXC_VEC
  2. eret -> epc
  3. stall -> pc (hold)
  4. taken -> b_tgt
  5. jmp_op in {1,2} -> j_tgt
  6. jmp_op in {3,4} -> jr_pc
  7. otherwise -> pc+4
- intreq and eret override stall.
- While stall=1 and there is no intreq/eret, br_op and jmp_op are ignored; the stalled instruction re-presents them later.
- Register update: pc <= npc on every clk edge when reset=0. One-cycle latency from request to pc.
- redirect = 1 for priorities 1, 2, 4, 5 and 6; 0 for hold or pc+4.
- Branch and jump in the same cycle (illegal encoding): the branch wins per the priority list; no error is flagged.
- RAS update enable is "no reset, no intreq, no eret, no stall". When enabled:
  - Push on jmp_op==2 (jal) or 4 (jalr). The value is id_pc4+4, the return address after the delay slot.
  - Pop on jmp_op==3 with jr_is_ra=1.
- RAS organisation:
  - Circular buffer with a top pointer that increments on push and decrements on pop, modulo RAS_DEPTH.
  - On push when full (count==RAS_DEPTH), the oldest entry is overwritten and count saturates.
  - On pop when empty, nothing changes; the pointer and count do not wrap.
  - Push and pop cannot coincide, because jmp_op is a single field.
- ras_top is a combinational read of the entry at the top pointer, gated to 0 when empty.
- The RAS is advisory only and never alters npc in this generation.

Decomposition:
- Shared package pc_gen_pkg holds:
  - localparams for the br_op codes (BR_NONE..BR_BLTZ) and jmp_op codes (JMP_NONE, JMP_J, JMP_JAL, JMP_JR, JMP_JALR);
  - default RESET_PC and EXC_VEC.
- One sub-module is natural: pc_ras, parametrised by ADDR_W and RAS_DEPTH, with ports push, pop, push_data, top, valid, count.
- pc_gen instantiates pc_ras.

Test Plan:
- Reset, then 3 idle cycles -> pc sequence 0x3000, 0x3004, 0x3008, 0x300C; ras_count=0.
- beq with id_pc4=0x3010, offset=0xFFFF_FFFE, zero=1 -> npc=0x3008 and redirect=1; next cycle pc=0x3008. With zero=0 -> pc=pc+4.
- stall=1 together with bne taken -> pc holds for every stalled cycle. In the same state, intreq=1 -> next pc=0x4180. eret with epc=0x3100 -> next pc=0x3100.
- RAS_DEPTH=4, five jal at id_pc4=0x3004, 0x3104, 0x3204, 0x3304, 0x3404 -> ras_count stays 4 and ras_top=0x3408. Five jr $31 pops -> ras_top reads 0x3308, 0x3208, 0x3108, then empty (ras_top=0, ras_valid=0). The fifth pop changes nothing.
- jal presented with intreq=1 -> pc=0x4180 and ras_count unchanged. Synchronous reset asserted with jal active -> pc=0x3000 and the RAS is cleared.
- j with id_pc4=0xA000_0004, instr_index=0x000_0040 -> pc=0xA000_0100. jr with jr_pc=0x3002 -> pc_misalign=1 on the following cycle.
